stepper_axis_seq: RTL and testbench

- Parametrised successor to the single-shot vertical motor pulse controller.
- Drives one stepper axis (step/dir) through a latched move programme: direction setup, N steps at a programmable half-period, a dwell, repeated R times with optional direction alternation (zig-zag scan).
- Tracks signed axis position; supports abort.
- Sits between the scan sequencer (start/abort/config) and the motor driver pins.
- Pure counter arithmetic: no multiplier or divider IP; the host supplies all times in clk cycles.

---
 rtl/stepper_axis_seq_if.sv | 41 ++++
 rtl/stepper_axis_seq.sv | 224 ++++++++++++++++++++++
 tb/tb_stepper_axis_seq.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/stepper_axis_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : stepper_axis_seq_if
//  Description : Host-side control/config and motor-pin bundle for one
//                stepper axis sequencer. slave = sequencer, master = host.
//  Revision    : 1.0  initial release
// ============================================================================
interface stepper_axis_seq_if #(
  parameter int CNT_W = 32,
  parameter int POS_W = 32,
  parameter int REP_W = 16
) ();
  logic             start_i;
  logic             abort;
  logic [CNT_W-1:0] cfg_half_period;
  logic [CNT_W-1:0] cfg_steps;
  logic [CNT_W-1:0] cfg_dwell;
  logic [REP_W-1:0] cfg_repeats;
  logic             cfg_dir;
  logic             cfg_alt_dir;
  logic             pos_clear;
  logic             pwm_pulse;
  logic             pwm_dir;
  logic             busy;
  logic             event_done;
  logic             aborted;
  logic [POS_W-1:0] position;

  modport slave (
    input  start_i, abort, cfg_half_period, cfg_steps, cfg_dwell,
           cfg_repeats, cfg_dir, cfg_alt_dir, pos_clear,
    output pwm_pulse, pwm_dir, busy, event_done, aborted, position
  );

  modport master (
    output start_i, abort, cfg_half_period, cfg_steps, cfg_dwell,
           cfg_repeats, cfg_dir, cfg_alt_dir, pos_clear,
    input  pwm_pulse, pwm_dir, busy, event_done, aborted, position
  );
endinterface
`default_nettype wire

// File: rtl/stepper_axis_seq.sv
`default_nettype none
// ============================================================================
//  Module      : stepper_axis_seq
//  Description : Stepper axis programme sequencer. Runs R repeats of
//                {dir setup, N steps of 2*H cycles, dwell D}, optionally
//                alternating direction, and tracks signed step position.
//  Revision    : 1.0  initial release
// ============================================================================
module stepper_axis_seq #(
  parameter int CNT_W     = 32,
  parameter int POS_W     = 32,
  parameter int REP_W     = 16,
  parameter int DIR_SETUP = 16
) (
  input  logic               clk,
  input  logic               rst,
  stepper_axis_seq_if.slave  bus
);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(DIR_SETUP - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_RUN   = 3'd2,
    S_DWELL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] step_cnt, step_n;
  logic [REP_W-1:0] rep_cnt, rep_n;
  logic             dir, dir_n;
  logic             phase, phase_n;     // 1 = high half of the current step

  // Latched programme, stored as terminal counts (value - 1)
  logic [CNT_W-1:0] hp_last, steps_last, dwell_last;
  logic [REP_W-1:0] reps_last;
  logic             steps_zero, dwell_zero, alt_dir;

  logic             sync1, sync2, sync3;
  logic             start_edge, accept, repeat_end;
  logic             pulse, pulse_n, aborted_q;
  logic [POS_W-1:0] position;

  assign start_edge = sync2 & ~sync3;
  assign pulse      = (state == S_RUN) && phase;

  // Two-flop synchroniser plus one history flop for rising-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= bus.start_i;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // FSM state and sequencing counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      step_cnt <= '0;
      rep_cnt  <= '0;
      dir      <= 1'b0;
      phase    <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      step_cnt <= step_n;
      rep_cnt  <= rep_n;
      dir      <= dir_n;
      phase    <= phase_n;
    end
  end

  // Capture and normalise the programme when a start is accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      hp_last    <= '0;
      steps_last <= '0;
      dwell_last <= '0;
      reps_last  <= '0;
      steps_zero <= 1'b0;
      dwell_zero <= 1'b0;
      alt_dir    <= 1'b0;
    end else if (accept) begin
      hp_last    <= (bus.cfg_half_period == '0) ? '0 : bus.cfg_half_period - CNT_W'(1);
      steps_last <= bus.cfg_steps - CNT_W'(1);
      dwell_last <= bus.cfg_dwell - CNT_W'(1);
      reps_last  <= (bus.cfg_repeats == '0) ? '0 : bus.cfg_repeats - REP_W'(1);
      steps_zero <= (bus.cfg_steps == '0);
      dwell_zero <= (bus.cfg_dwell == '0);
      alt_dir    <= bus.cfg_alt_dir;
    end
  end

  // Next-state logic; abort overrides everything at the end
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    step_n     = step_cnt;
    rep_n      = rep_cnt;
    dir_n      = dir;
    phase_n    = phase;
    accept     = 1'b0;
    repeat_end = 1'b0;

    case (state)
      S_IDLE: begin
        if (start_edge) begin
          accept  = 1'b1;
          state_n = S_SETUP;
          cnt_n   = '0;
          step_n  = '0;
          rep_n   = '0;
          dir_n   = bus.cfg_dir;
          phase_n = 1'b0;
        end
      end
      S_SETUP: begin
        if (cnt == SETUP_LAST) begin
          cnt_n = '0;
          if (!steps_zero) begin
            state_n = S_RUN;
            phase_n = 1'b1;
            step_n  = '0;
          end else if (!dwell_zero) begin
            state_n = S_DWELL;
          end else begin
            repeat_end = 1'b1;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_RUN: begin
        if (cnt == hp_last) begin
          cnt_n = '0;
          if (phase) begin
            phase_n = 1'b0;
          end else if (step_cnt == steps_last) begin
            if (dwell_zero) repeat_end = 1'b1;
            else            state_n    = S_DWELL;
          end else begin
            step_n  = step_cnt + CNT_W'(1);
            phase_n = 1'b1;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_DWELL: begin
        if (cnt == dwell_last) begin
          cnt_n      = '0;
          repeat_end = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    // Shared end-of-repeat decision: next repeat or finish
    if (repeat_end) begin
      cnt_n   = '0;
      phase_n = 1'b0;
      if (rep_cnt == reps_last) begin
        state_n = S_DONE;
      end else begin
        state_n = S_SETUP;
        rep_n   = rep_cnt + REP_W'(1);
        dir_n   = dir ^ alt_dir;
      end
    end

    // Abort drops the programme (and any coincident start); dir is held
    if (bus.abort) begin
      state_n = S_IDLE;
      accept  = 1'b0;
      cnt_n   = '0;
      phase_n = 1'b0;
      dir_n   = dir;
    end
  end

  assign pulse_n = (state_n == S_RUN) && phase_n;

  // Position moves on the edge where the step pulse rises; clear wins
  always_ff @(posedge clk) begin
    if (rst) begin
      position <= '0;
    end else if (bus.pos_clear) begin
      position <= '0;
    end else if (pulse_n && !pulse) begin
      position <= dir ? position + POS_W'(1) : position - POS_W'(1);
    end
  end

  // One-cycle abort acknowledge, issued from any state
  always_ff @(posedge clk) begin
    if (rst) aborted_q <= 1'b0;
    else     aborted_q <= bus.abort;
  end

  assign bus.pwm_pulse  = pulse;
  assign bus.pwm_dir    = dir;
  assign bus.busy       = (state != S_IDLE);
  assign bus.event_done = (state == S_DONE);
  assign bus.aborted    = aborted_q;
  assign bus.position   = position;

endmodule
`default_nettype wire

// File: tb/tb_stepper_axis_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stepper_axis_seq
//  Description : Scoreboard bench for stepper_axis_seq. Each programme pushes
//                its hand-computed outcome; a negedge monitor measures the
//                run and checks it when event_done or aborted appears.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_stepper_axis_seq;
  localparam int CNT_W     = 32;
  localparam int POS_W     = 32;
  localparam int REP_W     = 16;
  localparam int DIR_SETUP = 2;
  localparam int NO_RISE   = -1;
  localparam int NO_PER    = 9999;

  typedef struct {
    bit          is_abort;
    int          busy_len;
    int          pulses;
    int          hw_max;
    int          first_rise;
    int          per_min;
    logic [31:0] dirs;
    logic [31:0] pos;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stepper_axis_seq_if #(.CNT_W(CNT_W), .POS_W(POS_W), .REP_W(REP_W)) bus ();

  stepper_axis_seq #(
    .CNT_W(CNT_W), .POS_W(POS_W), .REP_W(REP_W), .DIR_SETUP(DIR_SETUP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void expect_ev(bit ab, int busy_len, int pulses, int hw,
                                    int first, int per, logic [31:0] dirs,
                                    logic [31:0] pos);
    exp_t e;
    e.is_abort = ab;  e.busy_len = busy_len; e.pulses = pulses;
    e.hw_max = hw;    e.first_rise = first;  e.per_min = per;
    e.dirs = dirs;    e.pos = pos;
    sb.push_back(e);
  endfunction

  // Monitor statistics for the run in progress
  int          m_busy, m_pulses, m_hw_cur, m_hw_max, m_first, m_per, m_since;
  logic [31:0] m_dirs;
  logic        prev_pulse;

  function automatic void clear_stats();
    m_busy = 0; m_pulses = 0; m_hw_cur = 0; m_hw_max = 0;
    m_first = NO_RISE; m_per = NO_PER; m_since = 0; m_dirs = '0;
  endfunction

  // Monitor: measure pulses/busy and check against the scoreboard on events
  always @(negedge clk) begin
    if (rst) begin
      clear_stats();
      prev_pulse = 1'b0;
    end else begin
      m_since++;
      if (bus.pwm_pulse && !prev_pulse) begin
        if (m_pulses == 0) m_first = m_busy;
        else if (m_since < m_per) m_per = m_since;
        m_since = 0;
        m_pulses++;
        m_dirs = {m_dirs[30:0], bus.pwm_dir};
        m_hw_cur = 0;
      end
      if (bus.pwm_pulse) begin
        m_hw_cur++;
        if (m_hw_cur > m_hw_max) m_hw_max = m_hw_cur;
      end
      if (bus.busy) m_busy++;
      prev_pulse = bus.pwm_pulse;
      if (bus.event_done || bus.aborted) begin
        if (sb.size() == 0) begin
          chk("unexpected_event", {62'd0, bus.event_done, bus.aborted}, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("aborted_flag", bus.aborted, e.is_abort);
          chk("done_flag", bus.event_done, !e.is_abort);
          chk("busy_cycles", m_busy, e.busy_len);
          chk("pulse_count", m_pulses, e.pulses);
          chk("pulse_high_max", m_hw_max, e.hw_max);
          chk("first_rise", m_first, e.first_rise);
          chk("period_min", m_per, e.per_min);
          chk("dir_at_rises", m_dirs, e.dirs);
          chk("position", bus.position, e.pos);
        end
        clear_stats();
      end
    end
  end

  task automatic set_cfg(input logic [31:0] hp, input logic [31:0] steps,
                         input logic [31:0] dwell, input logic [15:0] reps,
                         input logic d, input logic alt);
    bus.cfg_half_period = hp;
    bus.cfg_steps       = steps;
    bus.cfg_dwell       = dwell;
    bus.cfg_repeats     = reps;
    bus.cfg_dir         = d;
    bus.cfg_alt_dir     = alt;
  endtask

  task automatic wait_busy();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.busy) return;
    end
    chk("busy_rise_timeout", 64'd0, 64'd1);
  endtask

  // Raise start and return at the first negedge where busy is seen
  task automatic start_prog();
    bus.start_i = 1'b1;
    wait_busy();
    bus.start_i = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 500 && sb.size() != 0; i++) @(negedge clk);
    chk("drain_timeout", sb.size(), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start_i = 1'b0;
    bus.abort = 1'b0;
    bus.pos_clear = 1'b0;
    set_cfg(32'd4, 32'd3, 32'd5, 16'd1, 1'b1, 1'b0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_pulse", bus.pwm_pulse, 1'b0);
    chk("rst_dir", bus.pwm_dir, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.event_done, 1'b0);
    chk("rst_aborted", bus.aborted, 1'b0);
    chk("rst_position", bus.position, 64'd0);

    // Basic single repeat
    set_cfg(32'd4, 32'd3, 32'd5, 16'd1, 1'b1, 1'b0);
    expect_ev(1'b0, 32, 3, 4, 2, 8, 32'b111, 32'd3);
    start_prog();
    wait_drain();

    // Clear position while idle
    bus.pos_clear = 1'b1;
    @(negedge clk);
    bus.pos_clear = 1'b0;
    chk("pos_clear_idle", bus.position, 64'd0);

    // Zig-zag: three repeats alternating direction
    set_cfg(32'd4, 32'd3, 32'd5, 16'd3, 1'b1, 1'b1);
    expect_ev(1'b0, 94, 9, 4, 2, 8, 32'b111000111, 32'd3);
    start_prog();
    wait_drain();

    // Zero steps: setup + dwell only
    set_cfg(32'd4, 32'd0, 32'd5, 16'd2, 1'b1, 1'b0);
    expect_ev(1'b0, 15, 0, 0, NO_RISE, NO_PER, 32'd0, 32'd3);
    start_prog();
    wait_drain();

    // Half period 0 behaves as 1, negative direction, no dwell
    set_cfg(32'd0, 32'd4, 32'd0, 16'd1, 1'b0, 1'b0);
    expect_ev(1'b0, 11, 4, 1, 2, 2, 32'd0, 32'hFFFF_FFFF);
    start_prog();
    wait_drain();

    // Abort three cycles into the second pulse high phase
    set_cfg(32'd4, 32'd3, 32'd5, 16'd1, 1'b1, 1'b0);
    expect_ev(1'b1, 13, 2, 4, 2, 8, 32'b11, 32'd1);
    start_prog();
    repeat (12) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("pulse_low_after_abort", bus.pwm_pulse, 1'b0);
    chk("busy_low_after_abort", bus.busy, 1'b0);
    wait_drain();
    chk("dir_held_after_abort", bus.pwm_dir, 1'b1);

    // Abort on the same cycle the start edge is seen: start is dropped
    set_cfg(32'd4, 32'd0, 32'd1, 16'd1, 1'b1, 1'b0);
    expect_ev(1'b1, 0, 0, 0, NO_RISE, NO_PER, 32'd0, 32'd1);
    @(negedge clk);
    bus.start_i = 1'b1;
    repeat (2) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    repeat (4) @(negedge clk);
    bus.start_i = 1'b0;
    repeat (20) @(negedge clk);
    wait_drain();

    // Second start edge and cfg change mid-run are ignored
    set_cfg(32'd2, 32'd2, 32'd3, 16'd1, 1'b1, 1'b0);
    expect_ev(1'b0, 14, 2, 2, 2, 4, 32'b11, 32'd3);
    start_prog();
    repeat (3) @(negedge clk);
    bus.start_i = 1'b1;
    set_cfg(32'd7, 32'd9, 32'd9, 16'd5, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    bus.start_i = 1'b0;
    wait_drain();
    repeat (20) @(negedge clk);

    // pos_clear on the same edge as the first pulse rise: clear wins
    set_cfg(32'd2, 32'd3, 32'd0, 16'd1, 1'b1, 1'b0);
    expect_ev(1'b0, 15, 3, 2, 2, 4, 32'b111, 32'd2);
    start_prog();
    @(negedge clk);
    bus.pos_clear = 1'b1;
    @(negedge clk);
    bus.pos_clear = 1'b0;
    wait_drain();

    repeat (20) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
